// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter and its helpers.
//   state_t   : arbiter FSM states (IDLE, GRANT)
//   N_REQ_DEF : default requester count
//   clog2     : ceiling log2, used to size the hold counter
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 3;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Searches req in cyclic order last+1, last+2, ... (mod N_REQ) and returns
// the first set index.
//   req   in  [N_REQ-1:0] request vector
//   last  in  [ID_W-1:0]  index of the previous owner (lowest priority)
//   pick  out [ID_W-1:0]  winning index, 0 when nothing requested
//   valid out             at least one request present
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  pick,
  output logic             valid
);

  int idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter sharing one resource among N_REQ
// requesters. Grants are registered one-hot and held until Done or until
// the owner drops its request. A forced idle cycle separates grants.
// Optional macro ARB_TIMEOUT_EN adds a MAX_HOLD-cycle hold limit with a
// one-cycle Timeout pulse on forced release.
//   Clk      in   rising-edge clock
//   Reset    in   synchronous active-high reset
//   En       in   enables new grants (does not revoke a held grant)
//   Req      in   [N_REQ-1:0] level requests
//   Done     in   owner finished, releases current grant
//   Grant    out  [N_REQ-1:0] registered one-hot grant
//   GrantId  out  [ID_W-1:0] owner index, valid while Busy
//   Busy     out  a grant is held
//   Timeout  out  one-cycle pulse after a forced release
//
// state | meaning
// IDLE  | no owner; searching for next requester when En=1
// GRANT | one requester owns the resource
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [N_REQ-1:0] Req,
  input  logic             Done,
  output logic [N_REQ-1:0] Grant,
  output logic [ID_W-1:0]  GrantId,
  output logic             Busy,
  output logic             Timeout
);

  if (MAX_HOLD < 1 || (1 << ID_W) < N_REQ) begin : g_bad_params
    $error("rr_grant_arbiter: illegal MAX_HOLD/ID_W/N_REQ combination");
  end

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    pick;
  logic               pick_valid;
  logic               hold_hit;
  logic               release_now;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (Req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign hold_hit = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign Timeout  = timeout_q;
`else
  assign hold_hit = 1'b0;
  assign Timeout  = 1'b0;
`endif

  assign release_now = Done || !Req[id_q] || hold_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (En && pick_valid) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << pick;
          id_d    = pick;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          id_d    = '0;
          last_d  = id_q;
`ifdef ARB_TIMEOUT_EN
          // Pulse only when the limit is the sole reason for release.
          timeout_d = hold_hit && !Done && Req[id_q];
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign Grant   = grant_q;
  assign GrantId = id_q;
  assign Busy    = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter: directed steps followed by random
// traffic, all compared against a behavioural model of the arbitration
// rules. Build with ARB_TIMEOUT_EN to exercise the hold limit.
module tb_rr_grant_arbiter;

  localparam int N        = 3;
  localparam int IDW      = 2;
  localparam int MAXH     = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          En = 1'b0;
  logic [N-1:0]  Req = '0;
  logic          Done = 1'b0;
  logic [N-1:0]  Grant;
  logic [IDW-1:0] GrantId;
  logic          Busy;
  logic          Timeout;

  int checks = 0;
  int errors = 0;

  // behavioural model: owner index or -1 when idle
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;
  bit m_tmo   = 1'b0;

  rr_grant_arbiter #(.N_REQ(N), .ID_W(IDW), .MAX_HOLD(MAXH)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .En      (En),
    .Req     (Req),
    .Done    (Done),
    .Grant   (Grant),
    .GrantId (GrantId),
    .Busy    (Busy),
    .Timeout (Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input logic [N-1:0] rq, input bit dn);
    bit hit;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      if (en && rq != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (rq[c]) begin
            m_owner = c; m_cnt = 0;
            break;
          end
        end
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      hit = (m_cnt == MAXH - 1);
`else
      hit = 1'b0;
`endif
      if (dn || !rq[m_owner] || hit) begin
        m_tmo   = hit && !dn && rq[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_cnt++;
        m_tmo = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [N-1:0] rq, input bit dn);
    logic [N-1:0] eg;
    Reset = rst; En = en; Req = rq; Done = dn;
    @(posedge Clk);
    model_edge(rst, en, rq, dn);
    #1;
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
    chk("grant",   8'(Grant),   8'(eg));
    chk("busy",    8'(Busy),    8'(m_owner >= 0));
    chk("grantid", 8'(GrantId), (m_owner < 0) ? 8'd0 : 8'(m_owner));
    chk("timeout", 8'(Timeout), 8'(m_tmo));
  endtask

  initial begin
    int hold_len, tmo_cnt, ended, gi;
    logic [N-1:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

    // 1: reset, then idle with En=0
    for (int i = 0; i < 10; i++) step(1, 0, 3'b000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b000, 0);
    chk("t1_idle_grant", 8'(Grant), 8'h0);

    // 2: first grant, then hand-over with forced gap
    step(0, 1, 3'b001, 0);
    chk("t2_first", 8'(Grant), 8'h1);
    step(0, 1, 3'b011, 1);
    chk("t2_gap", 8'(Grant), 8'h0);
    step(0, 1, 3'b011, 0);
    chk("t2_second", 8'(Grant), 8'h2);
    step(0, 1, 3'b000, 0);
    step(1, 0, 3'b000, 0);

    // 3: round-robin order with one idle cycle between grants
    for (int g = 0; g < 4; g++) begin
      step(0, 1, 3'b111, 0);
      chk("t3_order", 8'(Grant), 8'(order[g]));
      step(0, 1, 3'b111, 1);
      chk("t3_gap", 8'(Grant), 8'h0);
    end

    // 4: En low keeps current grant, blocks new ones
    step(0, 1, 3'b111, 0);
    chk("t4_own1", 8'(Grant), 8'h2);
    step(0, 0, 3'b111, 0);
    step(0, 0, 3'b111, 0);
    chk("t4_held", 8'(Grant), 8'h2);
    step(0, 0, 3'b101, 0);
    chk("t4_drop", 8'(Grant), 8'h0);
    step(0, 0, 3'b101, 0);
    step(0, 0, 3'b101, 0);
    chk("t4_blocked", 8'(Grant), 8'h0);
    step(0, 1, 3'b101, 0);
    chk("t4_resume", 8'(Grant), 8'h4);
    step(0, 1, 3'b101, 1);

    // 5: hold limit / indefinite hold
    step(0, 1, 3'b001, 0);
    chk("t5_grant", 8'(Grant), 8'h1);
`ifdef ARB_TIMEOUT_EN
    hold_len = 1; tmo_cnt = 0; ended = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 3'b001, 0);
      if (Grant == 3'b001 && ended == 0) hold_len++;
      else ended = 1;
      if (Timeout) tmo_cnt++;
    end
    chk("t5_hold_len", 8'(hold_len), 8'd4);
    chk("t5_tmo_pulses", 8'(tmo_cnt), 8'd2);
`else
    hold_len = 1; tmo_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      step(0, 1, 3'b001, 0);
      if (Grant == 3'b001) hold_len++;
      if (Timeout) tmo_cnt++;
    end
    chk("t5_hold_len", 8'(hold_len), 8'd23);
    chk("t5_tmo_pulses", 8'(tmo_cnt), 8'd0);
`endif
    step(0, 1, 3'b000, 1);

    // 6: reset mid-grant with Done on the same edge
    step(0, 1, 3'b110, 0);
    chk("t6_busy", 8'(Busy), 8'h1);
    step(1, 1, 3'b110, 1);
    chk("t6_reset_idle", 8'(Grant), 8'h0);
    step(0, 1, 3'b111, 0);
    chk("t6_after_reset", 8'(Grant), 8'h1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      gi = $urandom_range(0, 63);
      step(gi == 0, $urandom_range(0, 3) != 0, N'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
